// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared icache definitions: FSM state encoding, AXI refill constants and line geometry.
package ysyx_23060025_icache_pkg;

    localparam int OFFSET_BITS = 4;   // 16-byte line
    localparam int LINE_WORDS  = 4;

    localparam logic [7:0] AXI_ARLEN     = 8'd3;
    localparam logic [2:0] AXI_ARSIZE    = 3'b010;
    localparam logic [1:0] AXI_ARBURST   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        MISS_R,
        RESP
    } icache_state_e;

endpackage

// File: rtl/ysyx_23060025_icache_if.sv
// IFU fetch port, fence.i flush and AXI read refill channel of the instruction cache.
interface ysyx_23060025_icache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] in_paddr;
    logic                  in_psel;
    logic                  in_pready;
    logic [31:0]           in_prdata;
    logic                  flush_i;

    logic                  out_arvalid;
    logic                  out_arready;
    logic [ADDR_WIDTH-1:0] out_araddr;
    logic [7:0]            out_arlen;
    logic [2:0]            out_arsize;
    logic [1:0]            out_arburst;
    logic                  out_rvalid;
    logic                  out_rready;
    logic [31:0]           out_rdata;
    logic [1:0]            out_rresp;
    logic                  out_rlast;

    // The cache side: serves the IFU and masters the AXI read channel.
    modport slave (
        input  in_paddr, in_psel, flush_i,
        output in_pready, in_prdata,
        output out_arvalid, out_araddr, out_arlen, out_arsize, out_arburst,
        input  out_arready,
        input  out_rvalid, out_rdata, out_rresp, out_rlast,
        output out_rready
    );

    // The environment side: IFU plus memory.
    modport master (
        output in_paddr, in_psel, flush_i,
        input  in_pready, in_prdata,
        input  out_arvalid, out_araddr, out_arlen, out_arsize, out_arburst,
        output out_arready,
        output out_rvalid, out_rdata, out_rresp, out_rlast,
        input  out_rready
    );

endinterface

// File: rtl/ysyx_23060025_icache_array.sv
// Direct-mapped tag/valid/data storage: one async read port, one synchronous write port, flash-clear of valid bits.
module ysyx_23060025_icache_array
    import ysyx_23060025_icache_pkg::*;
#(
    parameter int TAG_BITS   = 24,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flash_clr,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [1:0]            rd_word,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  inv_en,
    input  logic                  data_we,
    input  logic [1:0]            wr_word,
    input  logic [31:0]           wr_data,
    input  logic                  tag_we,
    input  logic [TAG_BITS-1:0]   wr_tag
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES*LINE_WORDS];

    // Installing a tag wins over invalidation; both lose to a flash clear.
    always_ff @(posedge clock) begin
        if (reset || flash_clr) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end else if (inv_en) begin
            valid_q[wr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (data_we) begin
            data_q[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped instruction cache, 16 lines x 16 bytes, AXI INCR-4 refill; hit returns in 2 cycles.
// Optional ICACHE_PERF_CNT_EN adds hit/miss counter outputs.
module ysyx_23060025_icache
    import ysyx_23060025_icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_23060025_icache_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hit_cnt_o,
    output logic [31:0]           perf_miss_cnt_o
`endif
);

    localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    icache_state_e state_q, state_d;

    // Byte-within-word bits are never needed, so only the word address is kept.
    logic [ADDR_WIDTH-3:0] paddr_q;
    logic [1:0]            beat_q;
    logic                  err_q;
    logic                  flush_pend_q;
    logic [31:0]           prdata_q;

    logic [TAG_BITS-1:0]   tag_w;
    logic [INDEX_BITS-1:0] index_w;
    logic [1:0]            word_w;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    logic                  flash_clr;
    logic                  inv_en;
    logic                  data_we;
    logic                  tag_we;

    assign tag_w   = paddr_q[ADDR_WIDTH-3 -: TAG_BITS];
    assign index_w = paddr_q[OFFSET_BITS-2 +: INDEX_BITS];
    assign word_w  = paddr_q[1:0];
    assign hit     = rd_valid && (rd_tag == tag_w);

    ysyx_23060025_icache_array #(
        .TAG_BITS   (TAG_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .flash_clr (flash_clr),
        .rd_index  (index_w),
        .rd_word   (word_w),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (index_w),
        .inv_en    (inv_en),
        .data_we   (data_we),
        .wr_word   (beat_q),
        .wr_data   (bus.out_rdata),
        .tag_we    (tag_we),
        .wr_tag    (tag_w)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A refilled line is invalidated first so an errored burst never leaves stale data marked valid.
    always_comb begin
        state_d   = state_q;
        flash_clr = 1'b0;
        inv_en    = 1'b0;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    flash_clr = 1'b1;
                end else if (bus.in_psel) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_d = RESP;
                end else begin
                    inv_en  = 1'b1;
                    state_d = MISS_AR;
                end
            end
            MISS_AR: begin
                if (bus.out_arready) begin
                    state_d = MISS_R;
                end
            end
            MISS_R: begin
                if (bus.out_rvalid) begin
                    data_we = 1'b1;
                    if (bus.out_rlast) begin
                        tag_we  = !err_q && (bus.out_rresp == AXI_RESP_OKAY);
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                flash_clr = flush_pend_q || bus.flush_i;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            paddr_q      <= '0;
            beat_q       <= 2'd0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            prdata_q     <= 32'd0;
        end else begin
            if (state_q == IDLE && !bus.flush_i && bus.in_psel) begin
                paddr_q <= bus.in_paddr[ADDR_WIDTH-1:2];
            end
            if (state_q == LOOKUP) begin
                beat_q <= 2'd0;
                err_q  <= 1'b0;
                if (hit) begin
                    prdata_q <= rd_data;
                end
            end
            if (state_q == MISS_R && bus.out_rvalid) begin
                beat_q <= beat_q + 2'd1;
                if (bus.out_rresp != AXI_RESP_OKAY) begin
                    err_q <= 1'b1;
                end
                if (beat_q == word_w) begin
                    prdata_q <= bus.out_rdata;
                end
            end
            if (state_q == RESP) begin
                flush_pend_q <= 1'b0;
            end else if (state_q != IDLE && bus.flush_i) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_hit_cnt_o  <= 32'd0;
            perf_miss_cnt_o <= 32'd0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
            end else begin
                perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
            end
        end
    end
`endif

    assign bus.in_pready   = (state_q == RESP);
    assign bus.in_prdata   = prdata_q;
    assign bus.out_arvalid = (state_q == MISS_AR);
    assign bus.out_araddr  = {paddr_q[ADDR_WIDTH-3:OFFSET_BITS-2], {OFFSET_BITS{1'b0}}};
    assign bus.out_arlen   = AXI_ARLEN;
    assign bus.out_arsize  = AXI_ARSIZE;
    assign bus.out_arburst = AXI_ARBURST;
    assign bus.out_rready  = (state_q == MISS_R);

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed bench for the icache: drives the IFU port and models an AXI memory serving one line per fetch.
module tb_ysyx_23060025_icache;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_23060025_icache_if #(.ADDR_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt_o;
    logic [31:0] perf_miss_cnt_o;
`endif

    ysyx_23060025_icache #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt_o  (perf_hit_cnt_o),
        .perf_miss_cnt_o (perf_miss_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_beats [4];
    logic [1:0]  mem_resp  [4];

    logic        r_saw_ar, r_ar_unstable, r_pready_after, r_aborted;
    logic [31:0] r_araddr, r_data;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    int          r_lat, r_ar_cyc;

    task automatic set_line(input logic [31:0] b0, b1, b2, b3);
        mem_beats[0] = b0; mem_beats[1] = b1; mem_beats[2] = b2; mem_beats[3] = b3;
        for (int i = 0; i < 4; i++) mem_resp[i] = 2'b00;
    endtask

    // One IFU fetch with the memory model answering; results land in the r_* variables.
    task automatic run_fetch(input logic [31:0] addr, input int stall, input int flush_beat,
                             input int reset_beat, input bit flush_with_psel);
        int  beat = 0;
        int  ar_cnt = 0;
        bit  done = 0;
        bit  flushed = 0;
        r_saw_ar = 0; r_ar_unstable = 0; r_aborted = 0; r_pready_after = 0;
        r_lat = -1; r_ar_cyc = -1; r_data = 32'd0; r_araddr = 32'd0;
        bus.in_paddr = addr;
        bus.in_psel  = 1'b1;
        if (flush_with_psel) bus.flush_i = 1'b1;
        for (int c = 1; c <= 300 && !done && !r_aborted; c++) begin
            @(posedge clock); #1;
            bus.flush_i = 1'b0;
            if (bus.out_rvalid) beat++;
            if (bus.in_pready) begin
                done = 1; r_data = bus.in_prdata; r_lat = c; bus.in_psel = 1'b0;
            end
            if (bus.out_arvalid) begin
                ar_cnt++;
                if (!r_saw_ar) begin
                    r_saw_ar = 1; r_ar_cyc = c; r_araddr = bus.out_araddr;
                    r_arlen = bus.out_arlen; r_arsize = bus.out_arsize; r_arburst = bus.out_arburst;
                end else if (bus.out_araddr !== r_araddr) begin
                    r_ar_unstable = 1;
                end
                bus.out_arready = (ar_cnt > stall);
            end else begin
                bus.out_arready = 1'b0;
            end
            bus.out_rvalid = 1'b0;
            bus.out_rlast  = 1'b0;
            if (bus.out_rready && beat < 4) begin
                if (beat == reset_beat) begin
                    reset = 1'b1; bus.in_psel = 1'b0; r_aborted = 1;
                end else begin
                    if (beat == flush_beat && !flushed) begin
                        bus.flush_i = 1'b1; flushed = 1;
                    end
                    bus.out_rvalid = 1'b1;
                    bus.out_rdata  = mem_beats[beat];
                    bus.out_rresp  = mem_resp[beat];
                    bus.out_rlast  = (beat == 3);
                end
            end
        end
        if (!done && !r_aborted) begin
            checks++; errors++;
            $display("FAIL fetch_timeout addr %h: no in_pready within 300 cycles", addr);
        end
        if (done) begin
            @(posedge clock); #1;
            r_pready_after = bus.in_pready;
        end
    endtask

    task automatic pulse_flush();
        bus.flush_i = 1'b1;
        @(posedge clock); #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.in_pready !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b expected 0", bus.in_pready); end
        checks++; if (bus.in_prdata !== 32'd0) begin errors++; $display("FAIL rst_prdata: got %h expected 0", bus.in_prdata); end
        checks++; if (bus.out_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", bus.out_arvalid); end
        checks++; if (bus.out_araddr !== 32'd0) begin errors++; $display("FAIL rst_araddr: got %h expected 0", bus.out_araddr); end
        checks++; if (bus.out_rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", bus.out_rready); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_cold_miss();
        set_line(32'h11, 32'h22, 32'h33, 32'h44);
        run_fetch(32'h8000_0004, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL cold_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_araddr !== 32'h8000_0000) begin errors++; $display("FAIL cold_araddr: got %h expected 80000000", r_araddr); end
        checks++; if (r_arlen !== 8'd3) begin errors++; $display("FAIL cold_arlen: got %0d expected 3", r_arlen); end
        checks++; if (r_arsize !== 3'b010) begin errors++; $display("FAIL cold_arsize: got %b expected 010", r_arsize); end
        checks++; if (r_arburst !== 2'b01) begin errors++; $display("FAIL cold_arburst: got %b expected 01", r_arburst); end
        checks++; if (r_ar_cyc !== 2) begin errors++; $display("FAIL cold_ar_cycle: got %0d expected 2", r_ar_cyc); end
        checks++; if (r_lat !== 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", r_lat); end
        checks++; if (r_data !== 32'h22) begin errors++; $display("FAIL cold_data: got %h expected 22", r_data); end
        checks++; if (r_pready_after !== 1'b0) begin errors++; $display("FAIL cold_pready_pulse: got %b expected 0", r_pready_after); end
    endtask

    task automatic test_hit();
        run_fetch(32'h8000_000C, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b0) begin errors++; $display("FAIL hit_ar: got %b expected 0", r_saw_ar); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d expected 2", r_lat); end
        checks++; if (r_data !== 32'h44) begin errors++; $display("FAIL hit_data: got %h expected 44", r_data); end
        checks++; if (r_pready_after !== 1'b0) begin errors++; $display("FAIL hit_pready_pulse: got %b expected 0", r_pready_after); end
        run_fetch(32'h8000_0000, 0, -1, -1, 0);
        checks++; if (r_data !== 32'h11) begin errors++; $display("FAIL hit_word0: got %h expected 11", r_data); end
    endtask

    task automatic test_conflict();
        set_line(32'hA1, 32'hA2, 32'hA3, 32'hA4);
        run_fetch(32'h8000_0100, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL conf_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_araddr !== 32'h8000_0100) begin errors++; $display("FAIL conf_araddr: got %h expected 80000100", r_araddr); end
        checks++; if (r_data !== 32'hA1) begin errors++; $display("FAIL conf_data: got %h expected a1", r_data); end
        set_line(32'h11, 32'h22, 32'h33, 32'h44);
        run_fetch(32'h8000_0000, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL conf_evict_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_data !== 32'h11) begin errors++; $display("FAIL conf_evict_data: got %h expected 11", r_data); end
        run_fetch(32'h8000_0008, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b0) begin errors++; $display("FAIL conf_rehit_ar: got %b expected 0", r_saw_ar); end
        checks++; if (r_data !== 32'h33) begin errors++; $display("FAIL conf_rehit_data: got %h expected 33", r_data); end
    endtask

    task automatic test_flush();
        pulse_flush();
        run_fetch(32'h8000_0004, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL flush_idle_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_data !== 32'h22) begin errors++; $display("FAIL flush_idle_data: got %h expected 22", r_data); end
        set_line(32'h55, 32'h66, 32'h77, 32'h88);
        run_fetch(32'h8000_0014, 0, 1, -1, 0);
        checks++; if (r_data !== 32'h66) begin errors++; $display("FAIL flush_missr_data: got %h expected 66", r_data); end
        run_fetch(32'h8000_0014, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL flush_missr_reaccess_ar: got %b expected 1", r_saw_ar); end
        run_fetch(32'h8000_0018, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b0) begin errors++; $display("FAIL flush_refill_hit_ar: got %b expected 0", r_saw_ar); end
        checks++; if (r_data !== 32'h77) begin errors++; $display("FAIL flush_refill_hit_data: got %h expected 77", r_data); end
        run_fetch(32'h8000_0018, 0, -1, -1, 1);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL flush_psel_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_ar_cyc !== 3) begin errors++; $display("FAIL flush_psel_ar_cycle: got %0d expected 3", r_ar_cyc); end
        checks++; if (r_data !== 32'h77) begin errors++; $display("FAIL flush_psel_data: got %h expected 77", r_data); end
    endtask

    task automatic test_error();
        set_line(32'hC1, 32'hC2, 32'hC3, 32'hC4);
        mem_resp[2] = 2'b10;
        run_fetch(32'h8000_0024, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL err_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_data !== 32'hC2) begin errors++; $display("FAIL err_data: got %h expected c2", r_data); end
        mem_resp[2] = 2'b00;
        run_fetch(32'h8000_0024, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL err_reaccess_ar: got %b expected 1", r_saw_ar); end
        run_fetch(32'h8000_0028, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b0) begin errors++; $display("FAIL err_clean_hit_ar: got %b expected 0", r_saw_ar); end
        checks++; if (r_data !== 32'hC3) begin errors++; $display("FAIL err_clean_hit_data: got %h expected c3", r_data); end
    endtask

    task automatic test_stall();
        set_line(32'hD1, 32'hD2, 32'hD3, 32'hD4);
        run_fetch(32'h8000_0030, 5, -1, -1, 0);
        checks++; if (r_araddr !== 32'h8000_0030) begin errors++; $display("FAIL stall_araddr: got %h expected 80000030", r_araddr); end
        checks++; if (r_ar_unstable !== 1'b0) begin errors++; $display("FAIL stall_araddr_stable: got %b expected 0", r_ar_unstable); end
        checks++; if (r_lat !== 12) begin errors++; $display("FAIL stall_latency: got %0d expected 12", r_lat); end
        checks++; if (r_data !== 32'hD1) begin errors++; $display("FAIL stall_data: got %h expected d1", r_data); end
    endtask

    task automatic test_reset_mid_refill();
        set_line(32'hE1, 32'hE2, 32'hE3, 32'hE4);
        run_fetch(32'h8000_0044, 0, -1, 2, 0);
        checks++; if (r_aborted !== 1'b1) begin errors++; $display("FAIL rstmid_reached_beat2: got %b expected 1", r_aborted); end
        @(posedge clock); #1;
        checks++; if (bus.in_pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready: got %b expected 0", bus.in_pready); end
        checks++; if (bus.out_rready !== 1'b0) begin errors++; $display("FAIL rstmid_rready: got %b expected 0", bus.out_rready); end
        checks++; if (bus.out_arvalid !== 1'b0) begin errors++; $display("FAIL rstmid_arvalid: got %b expected 0", bus.out_arvalid); end
        reset = 1'b0;
        run_fetch(32'h8000_0044, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL rstmid_reaccess_ar: got %b expected 1", r_saw_ar); end
        checks++; if (r_data !== 32'hE2) begin errors++; $display("FAIL rstmid_reaccess_data: got %h expected e2", r_data); end
        run_fetch(32'h8000_0030, 0, -1, -1, 0);
        checks++; if (r_saw_ar !== 1'b1) begin errors++; $display("FAIL rstmid_other_line_ar: got %b expected 1", r_saw_ar); end
    endtask

    initial begin
        bus.in_paddr    = 32'd0;
        bus.in_psel     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_arready = 1'b0;
        bus.out_rvalid  = 1'b0;
        bus.out_rdata   = 32'd0;
        bus.out_rresp   = 2'b00;
        bus.out_rlast   = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_error();
        test_stall();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
